// File: rtl/ipml_fifo_sync_v2_0_if.sv
// Producer/consumer bundle for ipml_fifo_sync_v2_0.
// A write happens on a clock edge where wr_en=1 and wr_full=0; a read happens where rd_en=1 and rd_empty=0.
interface ipml_fifo_sync_v2_0_if #(
    parameter int c_DEPTH_WIDTH = 9,
    parameter int c_DATA_WIDTH  = 32
);
    logic                     flush;
    logic [c_DATA_WIDTH-1:0]  wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic                     overflow;
    logic                     rd_en;
    logic [c_DATA_WIDTH-1:0]  rd_data;
    logic                     rd_valid;
    logic                     rd_empty;
    logic                     almost_empty;
    logic                     underflow;
    logic [c_DEPTH_WIDTH:0]   water_level;

    modport master (
        output flush, wr_data, wr_en, rd_en,
        input  wr_full, almost_full, overflow, rd_data, rd_valid,
               rd_empty, almost_empty, underflow, water_level
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en,
        output wr_full, almost_full, overflow, rd_data, rd_valid,
               rd_empty, almost_empty, underflow, water_level
    );
endinterface

// File: rtl/ipml_fifo_sync_v2_0.sv
// Single-clock FIFO on an inferred simple dual-port RAM with standard or
// first-word-fall-through read, optional output register, flush and threshold flags.
module ipml_fifo_sync_v2_0 #(
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_FWFT             = 0,
    parameter int c_OUTPUT_REG       = 0,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ipml_fifo_sync_v2_0_if.slave  fifo_if
);
    localparam int          AW     = c_DEPTH_WIDTH;
    localparam int          DW     = c_DATA_WIDTH;
    localparam bit          FWFT   = (c_FWFT != 0);
    localparam bit          OREG   = !FWFT && (c_OUTPUT_REG != 0);
    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_NUM = (AW+1)'(c_ALMOST_FULL_NUM);
    localparam logic [AW:0] AE_NUM = (AW+1)'(c_ALMOST_EMPTY_NUM);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic [AW:0]   ram_cnt;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_q;
    logic          mid_valid;
    logic          mid_valid_next;
    logic          out_valid;
    logic          out_valid_next;
    logic          wr_full_q;
    logic          almost_full_q;
    logic          overflow_q;
    logic          rd_empty_q;
    logic          almost_empty_q;
    logic          underflow_q;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_rd;
    logic          load_out;

    // mid_valid: ram_q holds a word not yet consumed; out_valid: out_q holds a word.
    always_comb begin
        wr_acc         = rst_n && !fifo_if.flush && fifo_if.wr_en && !wr_full_q;
        rd_acc         = rst_n && !fifo_if.flush && fifo_if.rd_en && !rd_empty_q;
        ram_cnt        = level - {{AW{1'b0}}, mid_valid} - {{AW{1'b0}}, out_valid};
        load_out       = 1'b0;
        ram_rd         = 1'b0;
        mid_valid_next = 1'b0;
        out_valid_next = 1'b0;
        if (FWFT) begin
            // Prefetch keeps both stages full so back-to-back pops stream.
            load_out       = mid_valid && (!out_valid || rd_acc);
            ram_rd         = rst_n && !fifo_if.flush && (ram_cnt != '0) && (!mid_valid || load_out);
            mid_valid_next = ram_rd || (mid_valid && !load_out);
            out_valid_next = load_out || (out_valid && !rd_acc);
        end else begin
            load_out       = mid_valid;
            ram_rd         = rd_acc;
            mid_valid_next = rd_acc;
            out_valid_next = mid_valid;
        end
        level_next = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level + (AW+1)'(1);
            2'b01:   level_next = level - (AW+1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fifo_if.flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            mid_valid      <= 1'b0;
            out_valid      <= 1'b0;
            out_q          <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (ram_rd) rd_ptr <= rd_ptr + AW'(1);
            if (load_out) out_q <= ram_q;
            level          <= level_next;
            mid_valid      <= mid_valid_next;
            out_valid      <= out_valid_next;
            wr_full_q      <= (level_next == DEPTH);
            almost_full_q  <= (level_next >= AF_NUM);
            almost_empty_q <= (level_next <= AE_NUM);
            rd_empty_q     <= FWFT ? !out_valid_next : (level_next == '0);
            overflow_q     <= fifo_if.wr_en && wr_full_q;
            underflow_q    <= fifo_if.rd_en && rd_empty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= fifo_if.wr_data;
    end

    // Registered RAM read port; cleared so rd_data reads zero after reset/flush.
    always_ff @(posedge clk) begin
        if (!rst_n || fifo_if.flush) ram_q <= '0;
        else if (ram_rd)             ram_q <= mem[rd_ptr];
    end

    assign fifo_if.rd_data      = (FWFT || OREG) ? out_q : ram_q;
    assign fifo_if.rd_valid     = (FWFT || OREG) ? out_valid : mid_valid;
    assign fifo_if.rd_empty     = rd_empty_q;
    assign fifo_if.wr_full      = wr_full_q;
    assign fifo_if.almost_full  = almost_full_q;
    assign fifo_if.almost_empty = almost_empty_q;
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.underflow    = underflow_q;
    assign fifo_if.water_level  = level;
endmodule

// File: tb/tb_ipml_fifo_sync_v2_0.sv
// Bench for ipml_fifo_sync_v2_0: standard, output-register and FWFT instances on one clock.
module tb_ipml_fifo_sync_v2_0;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ipml_fifo_sync_v2_0_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) s_if ();
    ipml_fifo_sync_v2_0_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) o_if ();
    ipml_fifo_sync_v2_0_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) f_if ();

    ipml_fifo_sync_v2_0 #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(0), .c_OUTPUT_REG(0),
        .c_ALMOST_FULL_NUM(508), .c_ALMOST_EMPTY_NUM(4)) u_std (.clk(clk), .rst_n(rst_n), .fifo_if(s_if.slave));
    ipml_fifo_sync_v2_0 #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(0), .c_OUTPUT_REG(1),
        .c_ALMOST_FULL_NUM(508), .c_ALMOST_EMPTY_NUM(4)) u_oreg (.clk(clk), .rst_n(rst_n), .fifo_if(o_if.slave));
    ipml_fifo_sync_v2_0 #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(1), .c_OUTPUT_REG(0),
        .c_ALMOST_FULL_NUM(508), .c_ALMOST_EMPTY_NUM(4)) u_fwft (.clk(clk), .rst_n(rst_n), .fifo_if(f_if.slave));

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;

    typedef struct {
        logic          wr, rd, fl;
        logic [DW-1:0] d;
        logic [AW:0]   lvl;
        logic          emp, vld;
        logic [DW-1:0] dat;
        logic          ovf, udf;
    } vec_t;
    vec_t vecs[11];

    function automatic vec_t mk(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d,
                                input logic [AW:0] lvl, input logic emp, input logic vld,
                                input logic [DW-1:0] dat, input logic ovf, input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.lvl = lvl;
        v.emp = emp; v.vld = vld; v.dat = dat; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_set(input logic w, input logic r, input logic fl, input logic [DW-1:0] d);
        s_if.wr_en = w; s_if.rd_en = r; s_if.flush = fl; s_if.wr_data = d;
    endtask

    task automatic o_set(input logic w, input logic r, input logic [DW-1:0] d);
        o_if.wr_en = w; o_if.rd_en = r; o_if.flush = 1'b0; o_if.wr_data = d;
    endtask

    task automatic f_set(input logic w, input logic r, input logic [DW-1:0] d);
        f_if.wr_en = w; f_if.rd_en = r; f_if.flush = 1'b0; f_if.wr_data = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic chk_std_cleared(input string tag);
        chk({tag, "_level"}, s_if.water_level, 0);
        chk({tag, "_empty"}, s_if.rd_empty, 1);
        chk({tag, "_aempty"}, s_if.almost_empty, 1);
        chk({tag, "_full"}, s_if.wr_full, 0);
        chk({tag, "_afull"}, s_if.almost_full, 0);
        chk({tag, "_valid"}, s_if.rd_valid, 0);
        chk({tag, "_data"}, s_if.rd_data, 0);
        chk({tag, "_ovf"}, s_if.overflow, 0);
        chk({tag, "_udf"}, s_if.underflow, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h11, 10'd1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h22, 10'd2, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  10'd1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  10'd1, 1'b0, 1'b0, 32'h11, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h33, 10'd1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  10'd0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  10'd0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  10'd0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 32'h44, 10'd1, 1'b0, 1'b0, 32'h33, 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 32'h55, 10'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,  10'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1);

        s_set(1'b0, 1'b0, 1'b0, '0);
        o_set(1'b0, 1'b0, '0);
        f_set(1'b0, 1'b0, '0);
        do_reset();

        chk_std_cleared("rst");
        chk("rst_oreg_valid", o_if.rd_valid, 0);
        chk("rst_oreg_data", o_if.rd_data, 0);
        chk("rst_fwft_empty", f_if.rd_empty, 1);
        chk("rst_fwft_valid", f_if.rd_valid, 0);

        // Short table of single-cycle transactions from empty
        for (int i = 0; i < 11; i++) begin
            s_set(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].d);
            tick();
            chk($sformatf("vec%0d_level", i), s_if.water_level, vecs[i].lvl);
            chk($sformatf("vec%0d_empty", i), s_if.rd_empty, vecs[i].emp);
            chk($sformatf("vec%0d_valid", i), s_if.rd_valid, vecs[i].vld);
            chk($sformatf("vec%0d_data", i), s_if.rd_data, vecs[i].dat);
            chk($sformatf("vec%0d_ovf", i), s_if.overflow, vecs[i].ovf);
            chk($sformatf("vec%0d_udf", i), s_if.underflow, vecs[i].udf);
            chk($sformatf("vec%0d_aempty", i), s_if.almost_empty, vecs[i].lvl <= 4);
            chk($sformatf("vec%0d_full", i), s_if.wr_full, 0);
        end
        s_set(1'b0, 1'b0, 1'b0, '0);

        // Fill to capacity, overflow, full wr+rd, drain, underflow, empty wr+rd
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            s_set(1'b1, 1'b0, 1'b0, i[DW-1:0]);
            exp_q.push_back(i[DW-1:0]);
            tick();
            chk("fill_level", s_if.water_level, i + 1);
            chk("fill_full", s_if.wr_full, (i + 1) == DEPTH);
            chk("fill_afull", s_if.almost_full, (i + 1) >= 508);
            chk("fill_aempty", s_if.almost_empty, (i + 1) <= 4);
        end
        s_set(1'b1, 1'b0, 1'b0, 32'd999);
        tick();
        chk("ovf_pulse", s_if.overflow, 1);
        chk("ovf_level", s_if.water_level, DEPTH);
        s_set(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("ovf_clear", s_if.overflow, 0);
        chk("ovf_level_hold", s_if.water_level, DEPTH);

        s_set(1'b1, 1'b1, 1'b0, 32'd777);
        tick();
        e = exp_q.pop_front();
        chk("fullrw_ovf", s_if.overflow, 1);
        chk("fullrw_level", s_if.water_level, DEPTH - 1);
        chk("fullrw_valid", s_if.rd_valid, 1);
        chk("fullrw_data", s_if.rd_data, e);
        chk("fullrw_full", s_if.wr_full, 0);

        for (int i = 1; i < DEPTH; i++) begin
            s_set(1'b0, 1'b1, 1'b0, '0);
            tick();
            e = exp_q.pop_front();
            chk("drain_valid", s_if.rd_valid, 1);
            chk("drain_data", s_if.rd_data, e);
            chk("drain_level", s_if.water_level, DEPTH - 1 - i);
        end
        chk("drain_empty", s_if.rd_empty, 1);
        chk("drain_aempty", s_if.almost_empty, 1);
        tick();
        chk("udf_pulse", s_if.underflow, 1);
        chk("udf_valid", s_if.rd_valid, 0);
        s_set(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("udf_clear", s_if.underflow, 0);
        s_set(1'b1, 1'b1, 1'b0, 32'hBEEF);
        tick();
        chk("emptyrw_udf", s_if.underflow, 1);
        chk("emptyrw_level", s_if.water_level, 1);
        chk("emptyrw_empty", s_if.rd_empty, 0);
        s_set(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("emptyrw_data", s_if.rd_data, 32'hBEEF);
        s_set(1'b0, 1'b0, 1'b0, '0);

        // Steady level 100 with simultaneous read/write across the pointer wrap
        do_reset();
        for (int i = 0; i < 100; i++) begin
            s_set(1'b1, 1'b0, 1'b0, 32'd1000 + i[DW-1:0]);
            exp_q.push_back(32'd1000 + i[DW-1:0]);
            tick();
        end
        for (int c = 0; c < 1000; c++) begin
            s_set(1'b1, 1'b1, 1'b0, 32'd5000 + c[DW-1:0]);
            exp_q.push_back(32'd5000 + c[DW-1:0]);
            tick();
            e = exp_q.pop_front();
            chk("wrap_level", s_if.water_level, 100);
            chk("wrap_valid", s_if.rd_valid, 1);
            chk("wrap_data", s_if.rd_data, e);
        end
        s_set(1'b0, 1'b0, 1'b0, '0);

        // Flush at level 300 together with a write
        do_reset();
        for (int i = 0; i < 300; i++) begin
            s_set(1'b1, 1'b0, 1'b0, i[DW-1:0]);
            tick();
        end
        chk("pre_flush_level", s_if.water_level, 300);
        s_set(1'b1, 1'b0, 1'b1, 32'h5);
        tick();
        chk_std_cleared("flush");
        s_set(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("flush_ovf_after", s_if.overflow, 0);

        // Reset mid-burst
        for (int i = 0; i < 40; i++) begin
            s_set(1'b1, i[0], 1'b0, 32'h300 + i[DW-1:0]);
            tick();
        end
        rst_n = 1'b0;
        s_set(1'b1, 1'b1, 1'b0, 32'h77);
        tick();
        chk_std_cleared("midrst");
        rst_n = 1'b1;
        s_set(1'b0, 1'b0, 1'b0, '0);

        // Output-register instance: two-cycle read latency
        o_set(1'b1, 1'b0, 32'h71); tick();
        o_set(1'b1, 1'b0, 32'h72); tick();
        o_set(1'b0, 1'b1, '0);     tick();
        chk("oreg_lat1_valid", o_if.rd_valid, 0);
        chk("oreg_level", o_if.water_level, 1);
        o_set(1'b0, 1'b0, '0);     tick();
        chk("oreg_lat2_valid", o_if.rd_valid, 1);
        chk("oreg_lat2_data", o_if.rd_data, 32'h71);
        tick();
        chk("oreg_drop_valid", o_if.rd_valid, 0);
        chk("oreg_hold_data", o_if.rd_data, 32'h71);

        // FWFT: single word falls through two cycles after the write
        f_set(1'b1, 1'b0, 32'hA5); tick();
        chk("fw_t0_valid", f_if.rd_valid, 0);
        chk("fw_t0_level", f_if.water_level, 1);
        chk("fw_t0_empty", f_if.rd_empty, 1);
        f_set(1'b0, 1'b0, '0);     tick();
        chk("fw_t1_valid", f_if.rd_valid, 0);
        tick();
        chk("fw_t2_valid", f_if.rd_valid, 1);
        chk("fw_t2_data", f_if.rd_data, 32'hA5);
        chk("fw_t2_empty", f_if.rd_empty, 0);
        f_set(1'b0, 1'b1, '0);     tick();
        chk("fw_pop_valid", f_if.rd_valid, 0);
        chk("fw_pop_level", f_if.water_level, 0);
        chk("fw_pop_empty", f_if.rd_empty, 1);
        tick();
        chk("fw_udf", f_if.underflow, 1);
        f_set(1'b0, 1'b0, '0);

        // FWFT: capacity includes the prefetched words, then a streaming drain
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            f_set(1'b1, 1'b0, 32'h8000 + i[DW-1:0]);
            exp_q.push_back(32'h8000 + i[DW-1:0]);
            tick();
        end
        chk("fw_full", f_if.wr_full, 1);
        chk("fw_full_level", f_if.water_level, DEPTH);
        f_set(1'b1, 1'b0, 32'hDEAD); tick();
        chk("fw_ovf", f_if.overflow, 1);
        chk("fw_ovf_level", f_if.water_level, DEPTH);
        f_set(1'b0, 1'b0, '0);       tick();
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            chk("fw_drain_valid", f_if.rd_valid, 1);
            chk("fw_drain_data", f_if.rd_data, e);
            f_set(1'b0, 1'b1, '0);
            tick();
        end
        f_set(1'b0, 1'b0, '0);
        chk("fw_end_valid", f_if.rd_valid, 0);
        chk("fw_end_level", f_if.water_level, 0);
        chk("fw_end_empty", f_if.rd_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ipml_fifo_sync_v2_0.md
Name: ipml_fifo_sync_v2_0

Overview:
- Single-clock, parametrised FIFO; next generation of the team's dual-clock SDPRAM-backed FIFO wrapper.
- Adds a first-word-fall-through (FWFT) mode, synchronous flush, and overflow/underflow pulses.
- Adds an optional registered output stage and threshold flags derived from a single water-level counter.
- Sits between single-clock-domain producers and consumers (pixel line buffers, command queues); no CDC inside.

Parameters:
- c_DEPTH_WIDTH, 9, log2 of capacity; legal range 4..16; capacity = 2^c_DEPTH_WIDTH words.
- c_DATA_WIDTH, 32, word width; legal range 1..1152.
- c_FWFT, 0, read mode: 0 = standard (data follows rd_en), 1 = first-word-fall-through.
- c_OUTPUT_REG, 0, standard mode only: adds one extra rd_data register stage. Ignored when c_FWFT=1.
- c_ALMOST_FULL_NUM, 508, almost_full asserted when level >= this value; legal 1..2^c_DEPTH_WIDTH.
- c_ALMOST_EMPTY_NUM, 4, almost_empty asserted when level <= this value; legal 0..2^c_DEPTH_WIDTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear, active high.
- wr_data  in  c_DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO full.
- almost_full  out  1  level >= c_ALMOST_FULL_NUM.
- overflow  out  1  one-cycle pulse: a write was rejected.
- rd_en  in  1  read request (pop).
- rd_data  out  c_DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid word.
- rd_empty  out  1  no word available to read.
- almost_empty  out  1  level <= c_ALMOST_EMPTY_NUM.
- underflow  out  1  one-cycle pulse: a read was rejected.
- water_level  out  c_DEPTH_WIDTH+1  words held, including any FWFT output-stage word.

Behaviour:
- Reset and flush values (rst_n low, or flush high, at a clock edge): wr_full=0, almost_full=0, overflow=0, rd_empty=1, almost_empty=1, underflow=0, water_level=0, rd_valid=0, rd_data=0, both pointers=0. RAM contents are not cleared.
- Priority: rst_n low > flush > wr_en/rd_en. wr_en and rd_en in a flush cycle are dropped, with no overflow or underflow pulse.
- All status outputs are registered and reflect the state at the start of the cycle.
- Write accept: wr_en && !wr_full. The word is stored at wr_ptr and wr_ptr increments, wrapping modulo 2^c_DEPTH_WIDTH.
- Read accept: rd_en && !rd_empty.
- Rejected write (wr_en && wr_full): overflow=1 on the next cycle; FIFO state unchanged.
- Rejected read (rd_en && rd_empty): underflow=1 on the next cycle; FIFO state unchanged.
- water_level: +1 per accepted write, -1 per accepted read, unchanged if both are accepted in one cycle. Updates one cycle after the accepting edge. Never exceeds 2^c_DEPTH_WIDTH and never goes below 0.
- wr_full = (water_level == 2^c_DEPTH_WIDTH).
- almost_full and almost_empty update in the same cycle as water_level.
- Full with wr_en && rd_en: the read is accepted and the write is rejected (overflow pulse); the level drops by 1.
- Standard mode, c_OUTPUT_REG=0:
  - rd_empty = (water_level == 0).
  - rd_data is valid and rd_valid=1 one cycle after an accepted read; otherwise rd_valid=0 and rd_data holds its last value.
  - First write into an empty FIFO: rd_empty deasserts 1 cycle after the write edge.
- Standard mode, c_OUTPUT_REG=1: read latency is 2 cycles; rd_valid is delayed to match.
- FWFT mode:
  - A prefetch stage moves the head word into the rd_data register whenever that register is empty or being popped.
  - rd_empty = !rd_valid, and rd_data holds the head word whenever rd_valid=1.
  - Accepted read: the next word appears on the following cycle if one is available; otherwise rd_valid falls.
  - First write into an empty FIFO: rd_valid=1 and rd_empty=0 two cycles after the write edge.
  - water_level counts the prefetched word; capacity remains 2^c_DEPTH_WIDTH.
- Empty with wr_en && rd_en:
  - Standard mode: the read is rejected (underflow pulse) and the write is accepted.
  - FWFT mode: same, since rd_valid=0.
- Wrap-around: pointers wrap silently; data order is preserved across the wrap.
- Storage: inferred simple dual-port RAM with a registered read port. The block contains no other memory.

Test Plan:
- Reset then 512 writes (data=i), c_DEPTH_WIDTH=9, c_FWFT=0 -> wr_full=1 after the 512th write, water_level=512, almost_full=1 from level 508; a 513th write gives overflow=1 for one cycle and level stays 512.
- Drain the above with continuous rd_en -> rd_data = 0..511 in order, each one cycle after its accepted read; rd_empty=1 after the last read; a further rd_en gives underflow=1 for one cycle.
- c_FWFT=1: write 0xA5 into an empty FIFO -> rd_valid=1 and rd_data=0xA5 two cycles later without rd_en; a pop with no further data gives rd_valid=0 and water_level=0.
- Simultaneous wr_en/rd_en at level 100 for 1000 cycles, crossing the pointer wrap -> level stays 100 and output order is correct.
- Full FIFO, wr_en=rd_en=1 -> read accepted, overflow pulses, level 511. Empty FIFO, wr_en=rd_en=1 -> underflow pulses, level 1.
- flush asserted at level 300 together with wr_en -> the next cycle shows level 0, rd_empty=1, almost_empty=1, rd_data=0, no overflow pulse. Repeat with rst_n=0 mid-burst -> same reset values.
